// File: rtl/cache_fill_fsm.sv
// Cache miss fill sequencer: fetches one WORDS-word block from pipelined memory and
// writes it into the data/tag arrays. Optional fill counter enabled by FILL_STATS_EN.
module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int WORDS       = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              fsm_busy,
  output logic [6:0]        set_index,
  output logic [WORDS-1:0]  word_enable,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [15:0]       data_out,
  output logic [15:0]       miss_count
);

  localparam int CNT_W = $clog2(WORDS) + 1;
  // Byte offset bits within a block: WORDS words of 2 bytes each.
  localparam int OFF_W = $clog2(WORDS) + 1;

  generate
    if (MEM_LATENCY < 1 || WORDS < 2) begin : g_param_check
      $error("cache_fill_fsm: MEM_LATENCY must be >= 1 and WORDS >= 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  r_last_addr;
  logic [6:0]         r_set_index;
  logic [CNT_W-1:0]   r_req_cnt;
  logic [CNT_W-1:0]   r_rsp_cnt;

  logic               w_req_active;
  logic [ADDR_W-1:0]  w_req_addr;
  logic               w_wr;
  logic               w_last;

  assign w_req_active = (r_state == FILL) && (r_req_cnt < CNT_W'(WORDS));
  assign w_req_addr   = r_base + (ADDR_W'(r_req_cnt) << 1);
  // Returns past the WORDS-th are dropped so a stray valid cannot overrun the line.
  assign w_wr         = (r_state == FILL) && memory_data_valid && (r_rsp_cnt < CNT_W'(WORDS));
  assign w_last       = w_wr && (r_rsp_cnt == CNT_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_last_addr <= '0;
      r_set_index <= '0;
      r_req_cnt   <= '0;
      r_rsp_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE) begin
        if (miss_detected) begin
          r_base      <= {miss_address[ADDR_W-1:OFF_W], OFF_W'(0)};
          r_set_index <= miss_address[10:4];
          r_req_cnt   <= '0;
          r_rsp_cnt   <= '0;
        end
      end else begin
        if (w_req_active) begin
          r_req_cnt   <= r_req_cnt + 1'b1;
          r_last_addr <= w_req_addr;
        end
        if (w_wr) begin
          r_rsp_cnt <= r_rsp_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    mem_read_en      = 1'b0;
    memory_address   = r_last_addr;
    fsm_busy         = 1'b0;
    word_enable      = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    data_out         = '0;
    case (r_state)
      IDLE: begin
        if (miss_detected) begin
          w_state_next = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (w_req_active) begin
          mem_read_en    = 1'b1;
          memory_address = w_req_addr;
        end
        if (w_wr) begin
          write_data_array = 1'b1;
          word_enable      = WORDS'(1) << r_rsp_cnt[CNT_W-2:0];
          data_out         = memory_data;
        end
        if (w_last) begin
          write_tag_array = 1'b1;
          w_state_next    = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign set_index = r_set_index;

`ifdef FILL_STATS_EN
  logic [15:0] r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_count <= '0;
    end else if (w_last && (r_miss_count != 16'hFFFF)) begin
      r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign miss_count = r_miss_count;
`else
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed scenarios plus randomized fills,
// checked every cycle against a transaction-level model of the fill protocol.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        fsm_busy;
  logic [6:0]  set_index;
  logic [7:0]  word_enable;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] data_out;
  logic [15:0] miss_count;

  cache_fill_fsm #(.ADDR_W(16), .WORDS(8), .MEM_LATENCY(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .fsm_busy          (fsm_busy),
    .set_index         (set_index),
    .word_enable       (word_enable),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .data_out          (data_out),
    .miss_count        (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: a fill is a block of 8 word requests at base+2k, answered in order.
  logic        m_busy;
  logic [15:0] m_base;
  logic [6:0]  m_set;
  int          m_nreq;
  int          m_nrsp;
  logic [15:0] m_last;
  int          m_cnt;
  logic [15:0] m_data_base;
  int          pend[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_miss_count();
`ifdef FILL_STATS_EN
    return 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic bit can_return();
    return (pend.size() > 0) && (cyc >= pend[0] + 4);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_base = '0; m_set = '0; m_nreq = 0; m_nrsp = 0;
    m_last = '0; m_cnt = 0; pend.delete();
  endtask

  // One clock cycle: drive after the falling edge, check mid-cycle, then advance the model.
  task automatic cycle(input logic miss, input logic [15:0] maddr, input logic vld);
    logic        e_rd, e_wr, e_tag;
    logic [15:0] e_addr, e_data;
    logic [7:0]  e_we;
    @(negedge clk);
    e_data = (vld && m_busy) ? 16'(m_data_base + 16'(m_nrsp)) : 16'($urandom);
    miss_detected     = miss;
    miss_address      = maddr;
    memory_data_valid = vld;
    memory_data       = e_data;
    #1;
    e_rd   = m_busy && (m_nreq < 8);
    e_addr = e_rd ? 16'(m_base + 16'(2 * m_nreq)) : m_last;
    e_wr   = m_busy && vld;
    e_tag  = e_wr && (m_nrsp == 7);
    e_we   = e_wr ? 8'(1 << m_nrsp) : 8'h00;
    chk("fsm_busy", {15'd0, fsm_busy}, {15'd0, m_busy});
    chk("mem_read_en", {15'd0, mem_read_en}, {15'd0, e_rd});
    chk("memory_address", memory_address, e_addr);
    chk("set_index", {9'd0, set_index}, {9'd0, m_set});
    chk("write_data_array", {15'd0, write_data_array}, {15'd0, e_wr});
    chk("word_enable", {8'd0, word_enable}, {8'd0, e_we});
    chk("write_tag_array", {15'd0, write_tag_array}, {15'd0, e_tag});
    if (e_wr) chk("data_out", data_out, e_data);
    chk("miss_count", miss_count, exp_miss_count());
    if (!m_busy) begin
      if (miss) begin
        m_busy = 1; m_base = {maddr[15:4], 4'h0}; m_set = maddr[10:4];
        m_nreq = 0; m_nrsp = 0; pend.delete();
      end
    end else begin
      if (e_rd) begin
        pend.push_back(cyc);
        m_last = e_addr;
        m_nreq++;
      end
      if (e_wr) begin
        void'(pend.pop_front());
        m_nrsp++;
        if (e_tag) begin
          m_busy = 0;
          if (m_cnt < 16'hFFFF) m_cnt++;
        end
      end
    end
    cyc++;
  endtask

  // mode 0: return as soon as allowed; 1: 3-cycle gap after word 4; 2: random gaps.
  task automatic do_fill(input logic [15:0] addr, input int mode, input bit busy_miss,
                         input int stop_after);
    int gapc = 0;
    int guard = 0;
    logic vld;
    cycle(1'b1, addr, 1'b0);
    while (m_busy && guard < 200 && !(stop_after >= 0 && m_nrsp == stop_after)) begin
      vld = can_return();
      if (mode == 1 && m_nrsp == 4 && vld && gapc < 3) begin
        vld = 0; gapc++;
      end else if (mode == 2 && vld && $urandom_range(0, 2) == 0) begin
        vld = 0;
      end
      cycle(busy_miss && ($urandom_range(0, 1) == 1), 16'hFFF0, vld);
      guard++;
    end
    if (stop_after < 0) $display("fill addr=%h base=%h set=%h done at cycle %0d", addr, m_base, m_set, cyc);
  endtask

  initial begin
    rst_n = 1'b0; miss_detected = 0; miss_address = '0;
    memory_data_valid = 0; memory_data = '0; m_data_base = 16'hA000;
    model_reset();
    #1;
    chk("reset fsm_busy", {15'd0, fsm_busy}, 16'h0000);
    chk("reset set_index", {9'd0, set_index}, 16'h0000);
    chk("reset memory_address", memory_address, 16'h0000);
    chk("reset miss_count", miss_count, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single fill at 0x1234 with prompt returns 0xA000..0xA007.
    do_fill(16'h1234, 0, 0, -1);
    chk("single set_index", {9'd0, set_index}, 16'h0023);
    cycle(1'b0, 16'h0, 1'b1);  // 9th valid after the fill is ignored

    // Gapped returns, then a fill with misses asserted throughout.
    m_data_base = 16'hB100;
    do_fill(16'h4A62, 1, 0, -1);
    m_data_base = 16'hC200;
    do_fill(16'h2008, 0, 1, -1);
    chk("busy miss set_index", {9'd0, set_index}, 16'h0000);
    repeat (3) cycle(1'b0, 16'h0, 1'b1);  // stray valids in IDLE

    // Reset after 3 returns: outputs drop immediately, no tag write.
    m_data_base = 16'hD300;
    do_fill(16'h5550, 0, 0, 3);
    @(negedge clk);
    rst_n = 1'b0; memory_data_valid = 1'b1; miss_detected = 1'b0;
    #1;
    model_reset();
    chk("midrst fsm_busy", {15'd0, fsm_busy}, 16'h0000);
    chk("midrst mem_read_en", {15'd0, mem_read_en}, 16'h0000);
    chk("midrst write_data_array", {15'd0, write_data_array}, 16'h0000);
    chk("midrst write_tag_array", {15'd0, write_tag_array}, 16'h0000);
    chk("midrst word_enable", {8'd0, word_enable}, 16'h0000);
    chk("midrst set_index", {9'd0, set_index}, 16'h0000);
    chk("midrst miss_count", miss_count, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1; memory_data_valid = 1'b0;
    m_data_base = 16'hE400;
    do_fill(16'h07F0, 0, 0, -1);
    chk("post-reset set_index", {9'd0, set_index}, 16'h007F);

    // Randomized fills with random gaps, busy misses and stray valids.
    for (int i = 0; i < 12; i++) begin
      m_data_base = 16'($urandom);
      do_fill(16'($urandom), 2, bit'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 3)) cycle(1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
    end

`ifdef FILL_STATS_EN
    // Saturation: preload near the top, two more fills must stick at 0xFFFF.
    @(negedge clk);
    force dut.r_miss_count = 16'hFFFE;
    #1;
    release dut.r_miss_count;
    m_cnt = 16'hFFFE;
    do_fill(16'h3330, 0, 0, -1);
    do_fill(16'h6660, 0, 0, -1);
    chk("saturated miss_count", miss_count, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
